// File: rtl/sram_like_axi_bridge_pkg.sv
//------------------------------------------------------------------------------
// Module : sram_axi_pkg
// Brief  : Shared encodings for the SRAM-like to AXI3 bridge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } state_e;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;

  localparam logic [3:0] LEN0       = 4'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] LOCK0      = 2'b00;
  localparam logic [3:0] CACHE0     = 4'd0;
  localparam logic [2:0] PROT0      = 3'd0;

  // Byte lanes follow the low address bits; data itself is never shifted.
  function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: calc_wstrb = 4'b0001 << addr_lo;
      SZ_HALF: calc_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: calc_wstrb = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_axi_bridge_arbiter.sv
//------------------------------------------------------------------------------
// Module : sram_like_arbiter
// Brief  : Fixed-priority (data over inst) grant and request latch.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_like_arbiter
  import sram_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              inst_addr_ok,
  output logic              data_addr_ok,
  output logic              grant,
  output logic              grant_wr,
  output src_e              lat_src,
  output logic              lat_wr,
  output logic [1:0]        lat_size,
  output logic [ADDR_W-1:0] lat_addr,
  output logic [DATA_W-1:0] lat_wdata
);

  logic w_pick_data;
  logic w_pick_inst;

  assign w_pick_data  = en && data_req;
  assign w_pick_inst  = en && !data_req && inst_req;
  assign data_addr_ok = w_pick_data;
  assign inst_addr_ok = w_pick_inst;
  assign grant        = w_pick_data || w_pick_inst;
  assign grant_wr     = data_req ? data_wr : inst_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_src   <= SRC_INST;
      lat_wr    <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      lat_src   <= w_pick_data ? SRC_DATA : SRC_INST;
      lat_wr    <= w_pick_data ? data_wr    : inst_wr;
      lat_size  <= w_pick_data ? data_size  : inst_size;
      lat_addr  <= w_pick_data ? data_addr  : inst_addr;
      lat_wdata <= w_pick_data ? data_wdata : inst_wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_axi_bridge.sv
//------------------------------------------------------------------------------
// Module : sram_like_axi_bridge
// Brief  : Inst/data SRAM-like masters onto one single-outstanding AXI3 port.
//          Optional sticky bus_err output under SRAM_AXI_RESP_ERR_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_like_axi_bridge
  import sram_axi_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
`ifdef SRAM_AXI_RESP_ERR_EN
  ,
  output logic              bus_err
`endif
);

  state_e            r_state;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_aw_done;
  logic              r_w_done;

  logic              w_arb_en;
  logic              w_grant;
  logic              w_grant_wr;
  src_e              r_src;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        w_id;
  logic              w_aw_fin;
  logic              w_w_fin;
  logic              w_rd_fin;
  logic              w_wr_fin;
  logic              w_fin;
  logic              w_unused;

  // Gating with rst keeps a reset cycle from producing handshakes.
  assign w_arb_en = (r_state == S_IDLE) && !rst;

  sram_like_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_arbiter (
    .clk          (clk),
    .rst          (rst),
    .en           (w_arb_en),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .inst_addr_ok (inst_addr_ok),
    .data_addr_ok (data_addr_ok),
    .grant        (w_grant),
    .grant_wr     (w_grant_wr),
    .lat_src      (r_src),
    .lat_wr       (r_wr),
    .lat_size     (r_size),
    .lat_addr     (r_addr),
    .lat_wdata    (r_wdata)
  );

  assign w_aw_fin = r_aw_done || (r_awvalid && awready);
  assign w_w_fin  = r_w_done  || (r_wvalid  && wready);
  assign w_rd_fin = (r_state == S_RD_DATA) && rvalid && !rst;
  assign w_wr_fin = (r_state == S_WR_RESP) && bvalid && !rst;
  assign w_fin    = w_rd_fin || w_wr_fin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            if (w_grant_wr) begin
              r_state   <= S_WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Later assignments win, so the done flags clear on the exit cycle.
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_id = (r_src == SRC_DATA) ? DATA_ID : INST_ID;

  assign arid    = w_id;
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arlen   = LEN0;
  assign arburst = BURST_INCR;
  assign arlock  = LOCK0;
  assign arcache = CACHE0;
  assign arprot  = PROT0;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign awid    = w_id;
  assign awaddr  = r_addr;
  assign awsize  = {1'b0, r_size};
  assign awlen   = LEN0;
  assign awburst = BURST_INCR;
  assign awlock  = LOCK0;
  assign awcache = CACHE0;
  assign awprot  = PROT0;
  assign awvalid = r_awvalid;

  assign wid     = w_id;
  assign wdata   = r_wdata;
  assign wstrb   = calc_wstrb(r_size, r_addr[1:0]);
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign inst_data_ok = w_fin && (r_src == SRC_INST);
  assign data_data_ok = w_fin && (r_src == SRC_DATA);

`ifdef SRAM_AXI_RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if ((w_rd_fin && (rresp != 2'b00)) || (w_wr_fin && (bresp != 2'b00))) begin
      bus_err <= 1'b1;
    end
  end
`endif

  // IDs are not used for routing; the latched source decides.
  assign w_unused = ^{rid, rlast, bid, rresp, bresp, r_wr};

endmodule

`default_nettype wire

// File: tb/tb_sram_like_axi_bridge.sv
//------------------------------------------------------------------------------
// Module : tb_sram_like_axi_bridge
// Brief  : Directed scoreboard bench for sram_like_axi_bridge.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_like_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0]  inst_size = 0, data_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
`ifdef SRAM_AXI_RESP_ERR_EN
  logic        bus_err;
`endif

  sram_like_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef SRAM_AXI_RESP_ERR_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_data; bit rd; logic [31:0] rdata; } rsp_t;
  typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; logic [31:0] data; logic [3:0] strb; } ax_t;

  rsp_t        rsp_q[$];
  ax_t         ar_q[$], aw_q[$], w_q[$];
  logic [31:0] rd_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AXI slave model with per-channel ready/valid latencies.
  int          ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
  logic [1:0]  r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
  int          ar_wait, aw_wait, w_wait, r_cnt, b_cnt;
  bit          p_ar, p_r, p_aw, p_w, p_b, r_pend, b_pend, aw_got, w_got;

  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rid = 0; bid = 0; rlast = 1; rresp = 0; bresp = 0; rdata = 32'h5A5A0F0F;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = 32'h5A5A0F0F; rresp = 0; bresp = 0;
        {p_ar, p_r, p_aw, p_w, p_b, r_pend, b_pend, aw_got, w_got} = '0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        rd_q.delete();
      end else begin
        if (p_ar) begin arready = 0; ar_wait = 0; r_pend = 1; r_cnt = 0; end
        if (p_r)  rvalid = 0;
        if (p_aw) begin awready = 0; aw_wait = 0; aw_got = 1; end
        if (p_w)  begin wready = 0; w_wait = 0; w_got = 1; end
        if (p_b)  bvalid = 0;
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
        if (arvalid && !arready) begin if (ar_wait >= ar_lat) arready = 1; else ar_wait++; end
        if (awvalid && !awready) begin if (aw_wait >= aw_lat) awready = 1; else aw_wait++; end
        if (wvalid && !wready)   begin if (w_wait >= w_lat) wready = 1; else w_wait++; end
        if (r_pend && !rvalid) begin
          if (r_cnt >= r_lat) begin
            rvalid = 1; r_pend = 0; rresp = r_resp_cfg; rid = 4'hF;
            rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEADBEEF;
          end else r_cnt++;
        end
        if (b_pend && !bvalid) begin
          if (b_cnt >= b_lat) begin bvalid = 1; b_pend = 0; bresp = b_resp_cfg; bid = 4'hF; end
          else b_cnt++;
        end
        p_ar = arvalid && arready; p_r = rvalid && rready;
        p_aw = awvalid && awready; p_w = wvalid && wready; p_b = bvalid && bready;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake.
  int   dok_cyc_inst = -1, dok_cyc_data = -1, ar_rise_cyc = -1;
  logic prev_arvalid = 0;
  rsp_t m_rsp;
  ax_t  m_ax;

  always @(negedge clk) begin
    if (arvalid && !prev_arvalid) ar_rise_cyc = cyc;
    prev_arvalid = arvalid;
    if (inst_data_ok || data_data_ok) begin
      check("dok_one_hot", {63'd0, inst_data_ok & data_data_ok}, 64'd0);
      check("dok_with_addr_ok", {63'd0, inst_addr_ok | data_addr_ok}, 64'd0);
      if (inst_data_ok) dok_cyc_inst = cyc; else dok_cyc_data = cyc;
      if (rsp_q.size() == 0) check("spurious_data_ok", 64'd1, 64'd0);
      else begin
        m_rsp = rsp_q.pop_front();
        check("rsp_src_is_data", {63'd0, data_data_ok}, {63'd0, m_rsp.is_data});
        if (m_rsp.rd) check("rsp_rdata", m_rsp.is_data ? data_rdata : inst_rdata, m_rsp.rdata);
      end
    end
    if (arvalid && arready) begin
      if (ar_q.size() == 0) check("unexpected_ar", 64'd1, 64'd0);
      else begin
        m_ax = ar_q.pop_front();
        check("arid", arid, m_ax.id);
        check("araddr", araddr, m_ax.addr);
        check("arsize", arsize, m_ax.size);
        check("ar_const", {arlen, arburst, arlock, arcache, arprot}, {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
      end
    end
    if (awvalid && awready) begin
      if (aw_q.size() == 0) check("unexpected_aw", 64'd1, 64'd0);
      else begin
        m_ax = aw_q.pop_front();
        check("awid", awid, m_ax.id);
        check("awaddr", awaddr, m_ax.addr);
        check("awsize", awsize, m_ax.size);
        check("aw_const", {awlen, awburst, awlock, awcache, awprot}, {4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
      end
    end
    if (wvalid && wready) begin
      if (w_q.size() == 0) check("unexpected_w", 64'd1, 64'd0);
      else begin
        m_ax = w_q.pop_front();
        check("wid", wid, m_ax.id);
        check("wdata", wdata, m_ax.data);
        check("wstrb", wstrb, m_ax.strb);
        check("wlast", {63'd0, wlast}, 64'd1);
      end
    end
  end

  task automatic issue(input bit is_data, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input logic [3:0] strb, input bit expect_rsp, output int acc);
    bit got = 0;
    logic [3:0] id = is_data ? 4'd1 : 4'd0;
    acc = -1;
    @(posedge clk); #1;
    if (is_data) begin data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd; end
    else begin inst_req = 1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (is_data ? data_addr_ok : inst_addr_ok) begin
        got = 1;
        acc = cyc;
        if (expect_rsp) rsp_q.push_back('{is_data, !wr, rd});
        if (wr) begin
          aw_q.push_back('{id, addr, {1'b0, size}, 32'd0, 4'd0});
          w_q.push_back('{id, 32'd0, 3'd0, wd, strb});
        end else begin
          ar_q.push_back('{id, addr, {1'b0, size}, 32'd0, 4'd0});
          rd_q.push_back(rd);
        end
      end
    end
    if (!got) check("addr_ok_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    if (is_data) data_req = 0; else inst_req = 0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (rsp_q.size() == 0) && !arvalid && !awvalid && !wvalid && !rready && !bready;
    end
    if (!done) check("idle_timeout", 64'd1, 64'd0);
  endtask

  typedef struct { logic [1:0] size; logic [31:0] addr; logic [31:0] wd; logic [3:0] strb; } wvec_t;
  wvec_t wv[4] = '{'{2'b01, 32'h80000002, 32'h12340000, 4'b1100},
                   '{2'b10, 32'h80000004, 32'hCAFEF00D, 4'b1111},
                   '{2'b01, 32'h80000000, 32'h00005678, 4'b0011},
                   '{2'b00, 32'h80000001, 32'h0000CD00, 4'b0010}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a0, a1, a_d, a_i;
  bit seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    check("rst_handshakes", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0);
    check("rst_rdata_pass", {inst_rdata, data_rdata}, {32'h5A5A0F0F, 32'h5A5A0F0F});
`ifdef SRAM_AXI_RESP_ERR_EN
    check("rst_bus_err", {63'd0, bus_err}, 64'd0);
`endif
    @(posedge clk); #2 rst = 0;

    // Instruction word read with one wait cycle on arready.
    ar_lat = 1; r_lat = 0;
    issue(0, 0, 2'b10, 32'hBFC00000, 0, 32'h3C1D0001, 4'd0, 1, a0);
    wait_idle();
    check("inst_rd_arvalid_lat", ar_rise_cyc - a0, 1);
    check("inst_rd_dok_lat", dok_cyc_inst - a0, 3);

    // Best-case back-to-back data reads.
    ar_lat = 0;
    issue(1, 0, 2'b10, 32'h80000000, 0, 32'h01234567, 4'd0, 1, a0);
    issue(1, 0, 2'b10, 32'h80000008, 0, 32'h89ABCDEF, 4'd0, 1, a1);
    wait_idle();
    check("best_rd_dok_lat", dok_cyc_data - a1, 2);
    check("next_addr_ok_gap", a1 - a0, 3);

    // Simultaneous requests: data wins, inst follows right after.
    fork
      issue(1, 0, 2'b10, 32'h80000010, 0, 32'h11112222, 4'd0, 1, a_d);
      issue(0, 0, 2'b10, 32'hBFC00004, 0, 32'h33334444, 4'd0, 1, a_i);
      begin
        @(posedge clk); @(negedge clk);
        check("arb_data_ok", {63'd0, data_addr_ok}, 64'd1);
        check("arb_inst_held", {63'd0, inst_addr_ok}, 64'd0);
      end
    join
    wait_idle();
    check("inst_after_data", a_i - dok_cyc_data, 1);

    // Byte write with slow awready and immediate wready.
    aw_lat = 3; w_lat = 0; b_lat = 1;
    fork
      issue(1, 1, 2'b00, 32'h80000003, 32'hAB000000, 0, 4'b1000, 1, a0);
      begin
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = awvalid; end
        @(negedge clk);
        check("wr_wvalid_dropped", {63'd0, wvalid}, 64'd0);
        check("wr_awvalid_held", {63'd0, awvalid}, 64'd1);
      end
    join
    wait_idle();

    aw_lat = 0; w_lat = 1; b_lat = 0;
    for (int i = 0; i < 4; i++) issue(1, 1, wv[i].size, wv[i].addr, wv[i].wd, 0, wv[i].strb, 1, a0);
    wait_idle();

    // Reset while waiting in RD_DATA.
    w_lat = 0; ar_lat = 0; r_lat = 8;
    issue(1, 0, 2'b10, 32'h80000020, 0, 32'h77778888, 4'd0, 0, a0);
    @(posedge clk); @(negedge clk);
    check("mid_rst_in_rd_data", {63'd0, rready}, 64'd1);
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    check("mid_rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    check("mid_rst_no_dok", {inst_data_ok, data_data_ok}, 2'b0);
    repeat (10) @(negedge clk);
    r_lat = 0;
    issue(1, 0, 2'b00, 32'h80000030, 0, 32'h0000009C, 4'd0, 1, a0);
    wait_idle();

`ifdef SRAM_AXI_RESP_ERR_EN
    b_resp_cfg = 2'b10;
    issue(1, 1, 2'b10, 32'h80000040, 32'h55AA55AA, 0, 4'b1111, 1, a0);
    wait_idle();
    check("bus_err_set", {63'd0, bus_err}, 64'd1);
    b_resp_cfg = 2'b00;
    issue(1, 0, 2'b10, 32'h80000044, 0, 32'h0BADF00D, 4'd0, 1, a0);
    wait_idle();
    check("bus_err_sticky", {63'd0, bus_err}, 64'd1);
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    check("bus_err_cleared", {63'd0, bus_err}, 64'd0);
`endif

    check("queues_drained", {32'd0, ar_q.size() + aw_q.size() + w_q.size() + rsp_q.size()}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_like_axi_bridge.md
Name: sram_like_axi_bridge

Overview:
- Downstream of the inst/data SRAM-to-SRAM-like converters.
- Arbitrates the instruction and data SRAM-like masters onto one AXI3 master port.
- Data has fixed priority over instruction.
- Exactly one transaction is outstanding at a time: single-beat reads and writes only, no bursts, no reordering.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; must be 32.
- INST_ID, 4'd0, arid for instruction reads.
- DATA_ID, 4'd1, arid/awid/wid for data accesses.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- inst_req, inst_wr  in  1 each  instruction master request / write flag.
- inst_size  in  2  00 byte, 01 half, 10 word.
- inst_addr, inst_wdata  in  32 each.
- inst_rdata  out  32  read data.
- inst_addr_ok, inst_data_ok  out  1 each  handshake pulses.
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok  same as inst_*, for the data master.
- arid  out 4; araddr out 32; arsize out 3; arvalid out 1; arready in 1.
- rid in 4; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1.
- awid out 4; awaddr out 32; awsize out 3; awvalid out 1; awready in 1.
- wid out 4; wdata out 32; wstrb out 4; wlast out 1; wvalid out 1; wready in 1.
- bid in 4; bresp in 2; bvalid in 1; bready out 1.
- arlen/awlen out 4 = 0; arburst/awburst out 2 = 01; arlock/awlock out 2 = 0; arcache/awcache out 4 = 0; arprot/awprot out 3 = 0. All constant.

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Reset:
  - state = IDLE.
  - All valid/ready outputs 0; addr_ok/data_ok 0.
  - Latched request registers 0; inst_rdata/data_rdata pass through rdata.
- IDLE arbitration:
  - grant = data_req ? DATA : inst_req ? INST : none.
  - <src>_addr_ok = 1 combinationally in IDLE for the granted source only. The loser sees addr_ok = 0 and keeps requesting.
  - On grant, latch src, wr, size, addr, wdata.
  - Next state: wr ? WR_REQ : RD_ADDR. No request: stay in IDLE.
- RD_ADDR:
  - arvalid = 1; araddr/arsize from latch; arsize = {1'b0, size}; arid per src.
  - Hold stable until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid (rlast assumed), <src>_data_ok = 1 for that cycle, with <src>_rdata = rdata in the same cycle.
  - Go to IDLE.
- WR_REQ:
  - awvalid and wvalid asserted from entry; each drops independently after its own handshake, tracked by aw_done/w_done.
  - wlast = 1.
  - wstrb: size 00 → 1<<addr[1:0]; size 01 → addr[1] ? 1100 : 0011; otherwise 1111.
  - wdata passes unshifted.
  - When both handshakes are done (same or different cycles), go to WR_RESP and clear the done flags.
- WR_RESP:
  - bready = 1.
  - On bvalid, <src>_data_ok pulses for 1 cycle; go to IDLE.
- Latency:
  - Request accepted in cycle N (addr_ok).
  - arvalid/awvalid asserted from N+1.
  - Best-case read: arready at N+1, rvalid at N+2 → data_ok at N+2.
  - Next addr_ok no earlier than N+3.
- Guarantees:
  - addr_ok and data_ok never assert in the same cycle.
  - data_ok is never asserted for a source that has no transaction in flight.
  - The request held by the non-granted source is not lost.
- Reset mid-transaction: synchronous return to IDLE and all valids drop. A dangling AXI transaction is accepted because the whole system resets together.
- AXI rid/bid are ignored for routing; the latched src is authoritative.
- rresp/bresp are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: SRAM_AXI_RESP_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit, sticky).
  - Set on the completing beat if rresp != 00 or bresp != 00.
  - Cleared only by rst.
  - data_ok still pulses normally.
- Undefined: no bus_err port; responses are not examined.

Decomposition:
- Package sram_axi_pkg holds:
  - FSM state encodings.
  - Size codes (SZ_BYTE/SZ_HALF/SZ_WORD).
  - Source select encodings.
  - Constant AXI field values (LEN0, BURST_INCR, CACHE0, PROT0).
- One sub-module: sram_like_arbiter. It performs fixed-priority grant plus latching of wr/size/addr/wdata/src.
- FSM and AXI channel drive remain in the top.

Test Plan:
- Inst read 0xBFC00000, size 10: inst_addr_ok in cycle 0; arvalid in cycle 1 with arid 0, arsize 010; rdata 0x3C1D0001 at cycle 3 → inst_data_ok=1 with inst_rdata=0x3C1D0001 in cycle 3.
- Simultaneous inst_req and data_req (read 0x80000010): data_addr_ok first, inst_addr_ok=0; after data_data_ok, inst granted next IDLE cycle.
- Data byte write to addr 0x80000003, wdata 0xAB000000: wstrb=1000, awsize=000; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle; bvalid → data_data_ok single pulse.
- Half write to addr 0x80000002: wstrb=1100. Word write: wstrb=1111.
- rst asserted during RD_DATA: next cycle state IDLE, rready=0, arvalid=0, no data_ok emitted.
- With SRAM_AXI_RESP_ERR_EN: bresp=10 on a write → bus_err=1 and stays 1 over subsequent OKAY transactions until rst.
